// File: rtl/irq_ctrl_vec.sv
// ============================================================================
// Module      : irq_ctrl_vec
// Description : Machine-interrupt controller. Level/edge capture, mie masking,
//               fixed-priority selection, held request with trap PC until mret.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_ctrl_vec #(
    parameter int          NUM_IRQ   = 16,
    parameter logic [31:0] EDGE_MASK = 32'h0000_0000,
    parameter int          CODE_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_IRQ-1:0]  irq_src,
    input  logic                mie_glb,
    input  logic [NUM_IRQ-1:0]  mie,
    input  logic [31:0]         mtvec,
    input  logic                irq_ack,
    input  logic                mret,
    output logic                irq_req,
    output logic [CODE_W-1:0]   int_code,
    output logic [31:0]         mcause_val,
    output logic [31:0]         trap_pc,
    output logic [NUM_IRQ-1:0]  mip_out,
    output logic                busy
);

    localparam logic [NUM_IRQ-1:0] c_edge_mask = EDGE_MASK[NUM_IRQ-1:0];

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [NUM_IRQ-1:0]  r_pend;
    logic [NUM_IRQ-1:0]  r_prev;
    logic                r_req;
    logic [CODE_W-1:0]   r_code;
    logic [31:0]         r_pc;
    logic                r_busy;

    logic [NUM_IRQ-1:0]  w_pend_nxt;
    logic [NUM_IRQ-1:0]  w_elig;
    logic [CODE_W-1:0]   w_winner;
    logic [31:0]         w_pc_calc;
    logic                w_ack_take;
    logic                w_req_nxt;
    logic [CODE_W-1:0]   w_code_nxt;
    logic [31:0]         w_pc_nxt;
    logic                w_busy_nxt;
    logic                w_unused_mtvec;

    assign w_unused_mtvec = mtvec[1];

    assign w_elig     = mie_glb ? (r_pend & mie) : '0;
    assign w_ack_take = (r_state == ST_REQ) && irq_ack;

    // Scan from the top so the lowest set index is written last and wins.
    always_comb begin
        w_winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_winner = CODE_W'(i);
            end
        end
    end

    assign w_pc_calc = mtvec[0] ? {mtvec[31:2] + 30'(w_winner), 2'b00}
                                : {mtvec[31:2], 2'b00};

    // Edge sources: a new rising edge beats the ack-driven clear.
    always_comb begin
        w_pend_nxt = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (c_edge_mask[i]) begin
                w_pend_nxt[i] = r_pend[i];
                if (w_ack_take && (r_code == CODE_W'(i))) begin
                    w_pend_nxt[i] = 1'b0;
                end
                if (irq_src[i] && !r_prev[i]) begin
                    w_pend_nxt[i] = 1'b1;
                end
            end else begin
                w_pend_nxt[i] = irq_src[i];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_code_nxt  = r_code;
        w_pc_nxt    = r_pc;
        w_busy_nxt  = r_busy;
        case (r_state)
            ST_IDLE: begin
                if (w_elig != '0) begin
                    w_code_nxt  = w_winner;
                    w_pc_nxt    = w_pc_calc;
                    w_req_nxt   = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (irq_ack) begin
                    w_req_nxt   = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = ST_SERVICE;
                end else if (w_elig == '0) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (mret) begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_req_nxt   = 1'b0;
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_pend  <= '0;
            r_prev  <= '0;
            r_req   <= 1'b0;
            r_code  <= '0;
            r_pc    <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_prev  <= irq_src;
            r_req   <= w_req_nxt;
            r_code  <= w_code_nxt;
            r_pc    <= w_pc_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign irq_req    = r_req;
    assign int_code   = r_code;
    assign mcause_val = {1'b1, 31'(r_code)};
    assign trap_pc    = r_pc;
    assign mip_out    = r_pend;
    assign busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_irq_ctrl_vec.sv
// ============================================================================
// Module      : tb_irq_ctrl_vec
// Description : Directed vector table, reset sequence and randomized run
//               against a behavioural model of irq_ctrl_vec.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_irq_ctrl_vec;

    localparam int          N  = 16;
    localparam logic [31:0] EM = 32'h0000_0804;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  src;
    logic          glb;
    logic [N-1:0]  mie;
    logic [31:0]   mtvec;
    logic          ack;
    logic          mret;
    logic          irq_req;
    logic [3:0]    int_code;
    logic [31:0]   mcause_val;
    logic [31:0]   trap_pc;
    logic [N-1:0]  mip_out;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    irq_ctrl_vec #(.NUM_IRQ(N), .EDGE_MASK(EM)) dut (
        .clk(clk), .reset(reset), .irq_src(src), .mie_glb(glb), .mie(mie),
        .mtvec(mtvec), .irq_ack(ack), .mret(mret), .irq_req(irq_req),
        .int_code(int_code), .mcause_val(mcause_val), .trap_pc(trap_pc),
        .mip_out(mip_out), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] src;
        logic        glb;
        logic [15:0] mie;
        logic [31:0] mtvec;
        logic        ack;
        logic        mret;
        logic        req;
        logic [3:0]  code;
        logic [31:0] pc;
        logic        busy;
        logic [15:0] mip;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [15:0] s, input logic g, input logic [15:0] m,
                       input logic [31:0] tv, input logic a, input logic r,
                       input logic e_req, input logic [3:0] e_code,
                       input logic [31:0] e_pc, input logic e_busy,
                       input logic [15:0] e_mip);
        vec_t v;
        v.src = s; v.glb = g; v.mie = m; v.mtvec = tv; v.ack = a; v.mret = r;
        v.req = e_req; v.code = e_code; v.pc = e_pc; v.busy = e_busy; v.mip = e_mip;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_req, input logic [3:0] e_code,
                           input logic [31:0] e_pc, input logic e_busy, input logic [15:0] e_mip);
        chk({tag, ".irq_req"}, 32'(irq_req), 32'(e_req));
        chk({tag, ".int_code"}, 32'(int_code), 32'(e_code));
        chk({tag, ".mcause"}, mcause_val, {1'b1, 27'd0, e_code});
        chk({tag, ".trap_pc"}, trap_pc, e_pc);
        chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
        chk({tag, ".mip"}, 32'(mip_out), 32'(e_mip));
    endtask

    // Behavioural model: spec rules expressed with integers and arithmetic.
    logic [15:0] m_pend, m_prev;
    int          m_state;   // 0 idle, 1 requesting, 2 in service
    logic        m_req, m_busy;
    logic [3:0]  m_code;
    logic [31:0] m_pc;

    task automatic model_reset();
        m_pend = '0; m_prev = '0; m_state = 0;
        m_req = 1'b0; m_busy = 1'b0; m_code = '0; m_pc = '0;
    endtask

    task automatic model_next();
        logic [15:0] elig;
        logic [15:0] np;
        int          win;
        elig = glb ? (m_pend & mie) : 16'h0;
        win  = -1;
        for (int i = 0; i < N; i++) if (elig[i] && win < 0) win = i;
        for (int i = 0; i < N; i++) begin
            if (EM[i]) np[i] = (src[i] & ~m_prev[i]) |
                               (m_pend[i] & ~(m_state == 1 && ack && int'(m_code) == i));
            else       np[i] = src[i];
        end
        if (m_state == 0) begin
            if (win >= 0) begin
                m_code  = 4'(win);
                m_pc    = mtvec[0] ? ((mtvec & 32'hFFFF_FFFC) + 32'(4 * win))
                                   : (mtvec & 32'hFFFF_FFFC);
                m_req   = 1'b1;
                m_state = 1;
            end
        end else if (m_state == 1) begin
            if (ack) begin
                m_req = 1'b0; m_busy = 1'b1; m_state = 2;
            end else if (win < 0) begin
                m_req = 1'b0; m_state = 0;
            end
        end else if (mret) begin
            m_busy = 1'b0; m_state = 0;
        end
        m_pend = np;
        m_prev = src;
    endtask

    initial begin
        reset = 1'b1; src = '0; glb = 1'b1; mie = 16'hFFFF;
        mtvec = 32'h0000_1000; ack = 1'b0; mret = 1'b0;

        //  src      glb mie      mtvec         ack mret | req code pc            busy mip
        add(16'h0020,1,16'hFFFF,32'h0000_1000,0,0,  0,4'd0,32'h0000_0000,0,16'h0020);
        add(16'h0020,1,16'hFFFF,32'h0000_1000,0,0,  1,4'd5,32'h0000_1000,0,16'h0020);
        add(16'h0000,1,16'hFFFF,32'h0000_1000,1,0,  0,4'd5,32'h0000_1000,1,16'h0000);
        add(16'h0000,1,16'hFFFF,32'h0000_1000,0,1,  0,4'd5,32'h0000_1000,0,16'h0000);
        add(16'h0208,1,16'hFFFF,32'h0000_2001,0,0,  0,4'd5,32'h0000_1000,0,16'h0208);
        add(16'h0208,1,16'hFFFF,32'h0000_2001,0,0,  1,4'd3,32'h0000_200C,0,16'h0208);
        add(16'h0200,1,16'hFFFF,32'h0000_2001,1,0,  0,4'd3,32'h0000_200C,1,16'h0200);
        add(16'h0200,1,16'hFFFF,32'h0000_2001,0,0,  0,4'd3,32'h0000_200C,1,16'h0200);
        add(16'h0200,1,16'hFFFF,32'h0000_2001,0,1,  0,4'd3,32'h0000_200C,0,16'h0200);
        add(16'h0200,1,16'hFFFF,32'h0000_2001,0,0,  1,4'd9,32'h0000_2024,0,16'h0200);
        add(16'h0000,1,16'hFFFF,32'h0000_2001,1,0,  0,4'd9,32'h0000_2024,1,16'h0000);
        add(16'h0000,1,16'hFFFF,32'h0000_2001,0,1,  0,4'd9,32'h0000_2024,0,16'h0000);
        add(16'h0004,1,16'hFFFF,32'h0000_2001,0,0,  0,4'd9,32'h0000_2024,0,16'h0004);
        add(16'h0004,1,16'hFFFF,32'h0000_2001,0,0,  1,4'd2,32'h0000_2008,0,16'h0004);
        add(16'h0004,1,16'hFFFF,32'h0000_2001,1,0,  0,4'd2,32'h0000_2008,1,16'h0000);
        add(16'h0004,1,16'hFFFF,32'h0000_2001,0,1,  0,4'd2,32'h0000_2008,0,16'h0000);
        add(16'h0004,1,16'hFFFF,32'h0000_2001,0,0,  0,4'd2,32'h0000_2008,0,16'h0000);
        add(16'h0000,1,16'hFFFF,32'h0000_2001,1,1,  0,4'd2,32'h0000_2008,0,16'h0000);
        add(16'h0010,1,16'hFFEF,32'h0000_2001,0,0,  0,4'd2,32'h0000_2008,0,16'h0010);
        add(16'h0010,1,16'hFFEF,32'h0000_2001,0,0,  0,4'd2,32'h0000_2008,0,16'h0010);
        add(16'h0010,1,16'hFFFF,32'h0000_2001,0,0,  1,4'd4,32'h0000_2010,0,16'h0010);
        add(16'h0010,0,16'hFFFF,32'h0000_2001,0,0,  0,4'd4,32'h0000_2010,0,16'h0010);
        add(16'h0000,0,16'hFFFF,32'h0000_2001,0,0,  0,4'd4,32'h0000_2010,0,16'h0000);
        add(16'h0000,1,16'hFFFF,32'h0000_2001,0,0,  0,4'd4,32'h0000_2010,0,16'h0000);
        add(16'h0040,1,16'hFFFF,32'h0000_2001,0,0,  0,4'd4,32'h0000_2010,0,16'h0040);
        add(16'h0040,1,16'hFFFF,32'h0000_2001,0,0,  1,4'd6,32'h0000_2018,0,16'h0040);
        add(16'h0042,1,16'hFFFF,32'h0000_3001,0,0,  1,4'd6,32'h0000_2018,0,16'h0042);
        add(16'h0042,1,16'hFFFF,32'h0000_3001,0,0,  1,4'd6,32'h0000_2018,0,16'h0042);
        add(16'h0002,1,16'hFFFF,32'h0000_3001,1,0,  0,4'd6,32'h0000_2018,1,16'h0002);
        add(16'h0002,1,16'hFFFF,32'h0000_3001,0,1,  0,4'd6,32'h0000_2018,0,16'h0002);
        add(16'h0002,1,16'hFFFF,32'h0000_3001,0,0,  1,4'd1,32'h0000_3004,0,16'h0002);
        add(16'h0000,1,16'hFFFF,32'h0000_3001,1,0,  0,4'd1,32'h0000_3004,1,16'h0000);

        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 1'b0, 4'd0, 32'h0, 1'b0, 16'h0);
        @(negedge clk);
        reset = 1'b0;

        foreach (tbl[k]) begin
            src = tbl[k].src; glb = tbl[k].glb; mie = tbl[k].mie;
            mtvec = tbl[k].mtvec; ack = tbl[k].ack; mret = tbl[k].mret;
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", k), tbl[k].req, tbl[k].code,
                    tbl[k].pc, tbl[k].busy, tbl[k].mip);
        end

        // Asynchronous reset while in SERVICE with a level source held high.
        src = 16'h0020; ack = 1'b0; mret = 1'b0;
        @(posedge clk);
        #1;
        chk_all("svc_hold", 1'b0, 4'd1, 32'h0000_3004, 1'b1, 16'h0020);
        #2 reset = 1'b1;
        #1;
        chk_all("async_rst", 1'b0, 4'd0, 32'h0, 1'b0, 16'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk_all("post_rst1", 1'b0, 4'd0, 32'h0, 1'b0, 16'h0020);
        @(posedge clk);
        #1;
        chk_all("post_rst2", 1'b1, 4'd5, 32'h0000_3014, 1'b0, 16'h0020);

        // Randomized run against the model.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            src   = 16'($urandom & $urandom);
            glb   = ($urandom_range(7) != 0);
            mie   = ~16'($urandom & $urandom & $urandom);
            mtvec = (c % 50 < 10) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            ack   = ($urandom_range(2) == 0);
            mret  = ($urandom_range(3) == 0);
            model_next();
            @(posedge clk);
            #1;
            chk_all($sformatf("rnd%0d", c), m_req, m_code, m_pc, m_busy, m_pend);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
